// File: rtl/loader_defs.sv
// Shared definitions for the boot-time ROM loader: state encodings, field
// widths, and the default ROM address width (matches CPU pc width).
package loader_defs;

  localparam int unsigned ROM_AW_DEFAULT = 15;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 16;
  localparam int unsigned STATE_W        = 4;

  localparam logic [STATE_W-1:0] ST_IDLE   = 4'd0;
  localparam logic [STATE_W-1:0] ST_HDR_HI = 4'd1;
  localparam logic [STATE_W-1:0] ST_HDR_LO = 4'd2;
  localparam logic [STATE_W-1:0] ST_W_HI   = 4'd3;
  localparam logic [STATE_W-1:0] ST_W_LO   = 4'd4;
  localparam logic [STATE_W-1:0] ST_CK_HI  = 4'd5;
  localparam logic [STATE_W-1:0] ST_CK_LO  = 4'd6;
  localparam logic [STATE_W-1:0] ST_RUN    = 4'd7;
  localparam logic [STATE_W-1:0] ST_ERROR  = 4'd8;

  // Byte-receiving states: every stream field is a hi/lo byte pair.
  function automatic logic is_rx_state(input logic [STATE_W-1:0] s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_W_HI) ||
           (s == ST_W_LO)   || (s == ST_CK_HI)  || (s == ST_CK_LO);
  endfunction

  function automatic logic is_hi_state(input logic [STATE_W-1:0] s);
    return (s == ST_HDR_HI) || (s == ST_W_HI) || (s == ST_CK_HI);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte pair to 16-bit word: latches the high byte, then presents
// {hi, lo} combinationally with a strobe on the low-byte transfer.
module word_assembler
  import loader_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] data,
  input  logic              take_hi,
  input  logic              take_lo,
  output logic [WORD_W-1:0] word,
  output logic              word_stb
);

  logic [BYTE_W-1:0] hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
    end else if (take_hi) begin
      hi_q <= data;
    end
  end

  assign word     = {hi_q, data};
  assign word_stb = take_lo;

endmodule

// File: rtl/rom_loader.sv
// Boot loader: receives count/words/checksum byte stream, writes the
// instruction ROM, verifies the checksum and releases the CPU from reset.
module rom_loader
  import loader_defs::*;
#(
  parameter int unsigned ROM_AW = ROM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ROM_AW-1:0] pc,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              rom_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ROM_AW-1:0] words_loaded
);

  localparam logic [ROM_AW:0] CNT_ONE = {{ROM_AW{1'b0}}, 1'b1};

  logic [STATE_W-1:0] state;
  logic [ROM_AW:0]    cnt;
  logic [ROM_AW:0]    cnt_inc;
  logic [WORD_W-1:0]  n_words;
  logic [WORD_W-1:0]  acc;
  logic [ROM_AW-1:0]  waddr;
  logic               hs;
  logic               take_hi;
  logic               take_lo;
  logic [WORD_W-1:0]  asm_word;
  logic               asm_stb;
  logic               hdr_bad;
  logic               last_word;

  assign rx_ready = is_rx_state(state);
  assign hs       = rx_valid & rx_ready;
  assign take_hi  = hs & is_hi_state(state);
  assign take_lo  = hs & ~is_hi_state(state);

  word_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (rx_data),
    .take_hi  (take_hi),
    .take_lo  (take_lo),
    .word     (asm_word),
    .word_stb (asm_stb)
  );

  assign cnt_inc   = cnt + CNT_ONE;
  assign last_word = (32'(cnt_inc) == 32'(n_words));
  assign hdr_bad   = (asm_word == '0) || (32'(asm_word) > (32'd1 << ROM_AW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      n_words   <= '0;
      acc       <= '0;
      waddr     <= '0;
      rom_we    <= 1'b0;
      rom_wdata <= '0;
    end else begin
      rom_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt   <= '0;
          acc   <= '0;
          waddr <= '0;
          state <= ST_HDR_HI;
        end
        ST_HDR_HI: if (take_hi) state <= ST_HDR_LO;
        ST_HDR_LO: begin
          if (asm_stb) begin
            n_words <= asm_word;
            state   <= hdr_bad ? ST_ERROR : ST_W_HI;
          end
        end
        ST_W_HI: if (take_hi) state <= ST_W_LO;
        ST_W_LO: begin
          if (asm_stb) begin
            rom_we    <= 1'b1;
            rom_wdata <= asm_word;
            waddr     <= cnt[ROM_AW-1:0];
            acc       <= acc + asm_word;
            cnt       <= cnt_inc;
            state     <= last_word ? ST_CK_HI : ST_W_HI;
          end
        end
        ST_CK_HI: if (take_hi) state <= ST_CK_LO;
        ST_CK_LO: begin
          if (asm_stb) state <= (asm_word == acc) ? ST_RUN : ST_ERROR;
        end
        ST_RUN, ST_ERROR: begin
          // Clear on the exit edge so words_loaded already reads 0 in IDLE.
          if (load_req) begin
            cnt   <= '0;
            acc   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign words_loaded = cnt[ROM_AW-1:0];
  assign rom_addr     = (state == ST_RUN) ? pc : waddr;
  assign cpu_reset    = (state != ST_RUN);
  assign busy         = (state == ST_IDLE) || is_rx_state(state);
  assign done         = (state == ST_RUN);
  assign err          = (state == ST_ERROR);

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader sitting directly upstream of the CPU: it receives a program image as a byte stream (from a UART receiver) over a valid/ready handshake and assembles big-endian 16-bit words. It writes them into the instruction ROM and verifies a 16-bit additive checksum. It holds the CPU's `reset` input high until a good image is loaded, then hands the ROM address port over to the CPU's `pc`.

## Interface
Parameters:
- `ROM_AW`, 15, instruction ROM address width; depth = 2^ROM_AW words

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `load_req`  in  1  one-cycle request to reload; honoured only in RUN or ERROR
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader accepts byte; transfer when `rx_valid & rx_ready`
- `pc`  in  ROM_AW  CPU fetch address
- `rom_addr`  out  ROM_AW  instruction ROM address
- `rom_wdata`  out  16  ROM write data
- `rom_we`  out  1  ROM write strobe, one cycle per word
- `cpu_reset`  out  1  drives CPU `reset`; 1 = hold CPU
- `busy`  out  1  load in progress (IDLE through CK_LO)
- `done`  out  1  image loaded and verified (RUN)
- `err`  out  1  load failed (ERROR)
- `words_loaded`  out  ROM_AW  words written in current load

## Operation
- Stream format, all fields high byte first: count N (16 bit), N program words, checksum C = sum of the N words mod 2^16.
- States: IDLE, HDR_HI, HDR_LO, W_HI, W_LO, CK_HI, CK_LO, RUN, ERROR.
- IDLE: clear word counter, checksum accumulator, `words_loaded`; unconditionally go to HDR_HI next cycle.
- HDR_HI/HDR_LO, W_HI/W_LO, CK_HI/CK_LO: `rx_ready`=1; each handshake stores the byte and advances; no handshake = hold state.
- HDR_LO handshake: N==0 or N>2^ROM_AW -> ERROR; else -> W_HI.
- W_LO handshake: write {hi,lo} at address = word counter; add to accumulator (16-bit wrap); increment counter; counter reaches N -> CK_HI, else -> W_HI.
- CK_LO handshake: received C == accumulator -> RUN, else -> ERROR.
- RUN: `rom_addr` = `pc` (combinational pass-through), `rom_we`=0, `cpu_reset`=0, `done`=1; `load_req` -> IDLE.
- ERROR: `cpu_reset`=1, `err`=1, `rx_ready`=0; bytes ignored; `load_req` -> IDLE; `err` clears on exit.
- `load_req` in any loading state: ignored.
- Outside RUN, `rom_addr` = write address register.

## Timing
- During `rst_n`=0 and after it: state IDLE; `cpu_reset`=1, `busy`=1, `rx_ready`=0, `rom_we`=0, `done`=0, `err`=0, `rom_wdata`=0, `words_loaded`=0.
- `rx_ready`, `busy`, `done`, `err`, `cpu_reset` are Moore outputs of the state register; `rom_addr` mux is combinational on state.
- Write latency: `rom_we`, `rom_wdata`, `rom_addr` valid in the cycle after the W_LO handshake, exactly one cycle. `words_loaded` increments in that same cycle.
- Back-to-back: with `rx_valid` held 1, one byte per cycle; image of N words occupies 1 (IDLE) + 2N+4 cycles; `cpu_reset` falls on the first RUN cycle.
- The last-word write and the CK_HI handshake may coincide; both complete.
- Reset assertion mid-load aborts immediately: ROM contents are left as is and the next load overwrites them.
- `load_req` in RUN: `cpu_reset` rises the next cycle (IDLE), same edge that leaves RUN.

## Structure
- Shared package/header `loader_defs`: state encodings, stream-field widths, default ROM_AW (matches CPU `pc` width of 15).
- One sub-module natural: `word_assembler` (hi-byte latch + {hi,lo} concatenation + strobe), reused for header, data, and checksum fields.
- Checksum accumulator and counters live in the top FSM.

## Test plan
- Stream 00 03 | 12 34 | AB CD | 00 01 | BE 02 (C=0xBE02), valid held 1 -> three writes 0:0x1234, 1:0xABCD, 2:0x0001; `cpu_reset` falls, `done`=1 after 11 cycles post-reset; then `rom_addr` tracks `pc`.
- Same image, checksum BE 03 -> ERROR, `err`=1, `cpu_reset` stays 1, `rx_ready`=0; `load_req` pulse -> IDLE, `err`=0, reload of the good image succeeds.
- Header 00 00 -> ERROR after the second byte, no `rom_we`; header 80 01 with ROM_AW=15 -> ERROR.
- Random `rx_valid` gaps (about 50% duty) on a 4-word image -> identical ROM contents and checksum result; no byte lost or duplicated.
- `rst_n` pulsed low after 2 of 4 words -> all outputs at reset values asynchronously; subsequent full image loads correctly, `words_loaded`=4.
- `load_req` during W_HI -> ignored, load completes normally; `load_req` in RUN -> `cpu_reset`=1 the next cycle, `words_loaded`=0.
